// File: rtl/muldiv_if.sv
// Operand/request and write-back bundle between the register file and muldiv_unit.
interface muldiv_if #(parameter int WIDTH = 32);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] rs1_data;
  logic [WIDTH-1:0] rs2_data;
  logic [4:0]       rd_in;
  logic             flush;
  logic             busy;
  logic             done;
  logic             wr_en;
  logic [4:0]       rd_out;
  logic [WIDTH-1:0] result;

  modport master (
    output start, op, rs1_data, rs2_data, rd_in, flush,
    input  busy, done, wr_en, rd_out, result
  );

  modport slave (
    input  start, op, rs1_data, rs2_data, rd_in, flush,
    output busy, done, wr_en, rd_out, result
  );
endinterface

// File: rtl/muldiv.sv
// Iterative RV32M multiply/divide: 32 radix-2 steps on magnitudes, signs fixed up on entry to DONE.
// Divide-by-zero and signed overflow skip the iteration and finish one edge after acceptance.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [4:0]       cnt;
  logic [2:0]       op_q;
  logic [4:0]       rd_q;
  logic             a_neg_q, b_neg_q;
  logic [WIDTH-1:0] b_mag_q;
  logic [WIDTH-1:0] acc_hi, acc_lo;

  logic             a_signed, b_signed, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             is_div, div_zero, ovf;
  logic [WIDTH-1:0] special_res;

  logic [WIDTH:0]   mul_sum, div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff, nxt_hi, nxt_lo, quo, rem, fin;
  logic [2*WIDTH-1:0] prod;

  // Request decode on the live inputs, used only at the accepting edge
  always_comb begin
    a_signed = (bus.op == 3'd1) || (bus.op == 3'd2) || (bus.op == 3'd4) || (bus.op == 3'd6);
    b_signed = (bus.op == 3'd1) || (bus.op == 3'd4) || (bus.op == 3'd6);
    a_neg    = a_signed && bus.rs1_data[WIDTH-1];
    b_neg    = b_signed && bus.rs2_data[WIDTH-1];
    a_mag    = a_neg ? -bus.rs1_data : bus.rs1_data;
    b_mag    = b_neg ? -bus.rs2_data : bus.rs2_data;
    is_div   = bus.op[2];
    div_zero = (bus.rs2_data == '0);
    ovf      = ((bus.op == 3'd4) || (bus.op == 3'd6)) &&
               (bus.rs1_data == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.rs2_data == '1);
    if (div_zero)
      special_res = bus.op[1] ? bus.rs1_data : '1;
    else
      special_res = bus.op[1] ? '0 : bus.rs1_data;
  end

  // One iteration: acc_lo holds multiplier / dividend-then-quotient, acc_hi the partial product / remainder
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, b_mag_q} : '0);
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, b_mag_q};
    div_diff  = div_shift[WIDTH-1:0] - b_mag_q;
    if (op_q[2]) begin
      nxt_hi = div_ge ? div_diff : div_shift[WIDTH-1:0];
      nxt_lo = {acc_lo[WIDTH-2:0], div_ge};
    end else begin
      nxt_hi = mul_sum[WIDTH:1];
      nxt_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end
    prod = {nxt_hi, nxt_lo};
    if (a_neg_q ^ b_neg_q)
      prod = -prod;
    quo = (a_neg_q ^ b_neg_q) ? -nxt_lo : nxt_lo;
    rem = a_neg_q ? -nxt_hi : nxt_hi;
    case (op_q)
      3'd0:                fin = prod[WIDTH-1:0];
      3'd1, 3'd2, 3'd3:    fin = prod[2*WIDTH-1:WIDTH];
      3'd4, 3'd5:          fin = quo;
      default:             fin = rem;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      op_q       <= '0;
      rd_q       <= '0;
      a_neg_q    <= 1'b0;
      b_neg_q    <= 1'b0;
      b_mag_q    <= '0;
      acc_hi     <= '0;
      acc_lo     <= '0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.wr_en  <= 1'b0;
      bus.rd_out <= '0;
      bus.result <= '0;
    end else begin
      bus.done  <= 1'b0;
      bus.wr_en <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && !bus.flush) begin
            op_q     <= bus.op;
            rd_q     <= bus.rd_in;
            a_neg_q  <= a_neg;
            b_neg_q  <= b_neg;
            b_mag_q  <= b_mag;
            acc_hi   <= '0;
            acc_lo   <= a_mag;
            cnt      <= '0;
            bus.busy <= 1'b1;
            if (is_div && (div_zero || ovf)) begin
              state      <= DONE;
              bus.result <= special_res;
              bus.rd_out <= bus.rd_in;
              bus.done   <= 1'b1;
              bus.wr_en  <= (bus.rd_in != 5'd0);
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (bus.flush) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end else begin
            acc_hi <= nxt_hi;
            acc_lo <= nxt_lo;
            cnt    <= cnt + 5'd1;
            if (cnt == 5'(WIDTH-1)) begin
              state      <= DONE;
              bus.result <= fin;
              bus.rd_out <= rd_q;
              bus.done   <= 1'b1;
              bus.wr_en  <= (rd_q != 5'd0);
            end
          end
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and randomized checks of muldiv_unit against a plain-arithmetic RV32M model.
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] last_res;

  muldiv_if #(.WIDTH(32)) bus();
  muldiv_unit #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = (op == 3'd1 || op == 3'd2) ? {{32{a[31]}}, a} : {32'h0, a};
    eb = (op == 3'd1) ? {{32{b[31]}}, b} : {32'h0, b};
    p  = ea * eb;
    case (op)
      3'd0: return p[31:0];
      3'd1, 3'd2, 3'd3: return p[63:32];
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        return $signed(a) / $signed(b);
      end
      3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && b == 0) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
    return 33;
  endfunction

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.rs1_data = a; bus.rs2_data = b; bus.rd_in = rd;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp);
    int edges;
    issue(op, a, b, rd);
    edges = 1;
    chk({tag, ".busy_after_accept"}, 32'(bus.busy), 32'd1);
    while (!bus.done && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
    chk({tag, ".latency"}, 32'(edges), 32'(ref_latency(op, a, b)));
    chk({tag, ".result"}, bus.result, exp);
    chk({tag, ".rd_out"}, 32'(bus.rd_out), 32'(rd));
    chk({tag, ".wr_en"}, 32'(bus.wr_en), 32'(rd != 5'd0));
    @(posedge clk); #1;
    chk({tag, ".done_cleared"}, 32'(bus.done), 32'd0);
    chk({tag, ".busy_cleared"}, 32'(bus.busy), 32'd0);
    last_res = exp;
  endtask

  initial begin
    int cyc;
    int done_seen;
    logic [2:0] r_op;
    logic [31:0] r_a, r_b;
    logic [4:0] r_rd;

    bus.start = 1'b0; bus.op = 3'd0; bus.rs1_data = '0; bus.rs2_data = '0;
    bus.rd_in = '0; bus.flush = 1'b0;
    #12;
    chk("reset.busy", 32'(bus.busy), 32'd0);
    chk("reset.done", 32'(bus.done), 32'd0);
    chk("reset.wr_en", 32'(bus.wr_en), 32'd0);
    chk("reset.rd_out", 32'(bus.rd_out), 32'd0);
    chk("reset.result", bus.result, 32'd0);
    @(negedge clk); rst = 1'b0;

    run_op("mul7x6",   3'd0, 32'd7, 32'd6, 5'd5, 32'h0000002A);
    run_op("mulh_m1",  3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1, 32'h00000000);
    run_op("mul_m1",   3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 32'h00000001);
    run_op("mulhu_m1", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 32'hFFFFFFFE);
    run_op("mulhsu_m1",3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4, 32'hFFFFFFFF);
    run_op("div_m7_2", 3'd4, 32'hFFFFFFF9, 32'd2, 5'd6, 32'hFFFFFFFD);
    run_op("rem_m7_2", 3'd6, 32'hFFFFFFF9, 32'd2, 5'd7, 32'hFFFFFFFF);
    run_op("divu100_7",3'd5, 32'd100, 32'd7, 5'd8, 32'd14);
    run_op("remu100_7",3'd7, 32'd100, 32'd7, 5'd9, 32'd2);
    run_op("divu5_0",  3'd5, 32'd5, 32'd0, 5'd10, 32'hFFFFFFFF);
    run_op("rem5_0",   3'd6, 32'd5, 32'd0, 5'd11, 32'd5);
    run_op("div_ovf",  3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h80000000);
    run_op("rem_ovf",  3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'h00000000);

    // flush held in IDLE must block acceptance
    @(negedge clk);
    bus.start = 1'b1; bus.flush = 1'b1; bus.op = 3'd0; bus.rs1_data = 32'd3; bus.rs2_data = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.flush = 1'b0;
    chk("flush_idle.busy", 32'(bus.busy), 32'd0);

    // new start mid-operation ignored, then flushed with no write-back
    issue(3'd0, 32'd11, 32'd13, 5'd20);
    cyc = 1; done_seen = 0;
    while (cyc < 20) begin
      if (cyc == 10) begin bus.start = 1'b1; bus.op = 3'd5; bus.rs2_data = 32'd0; end
      else bus.start = 1'b0;
      @(posedge clk); #1;
      cyc++;
      if (bus.done) done_seen++;
    end
    bus.start = 1'b0;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    chk("flush.busy", 32'(bus.busy), 32'd0);
    chk("flush.done", 32'(bus.done), 32'd0);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.done) done_seen++;
    end
    chk("flush.no_done", 32'(done_seen), 32'd0);
    chk("flush.result_held", bus.result, last_res);
    chk("flush.rd_held", 32'(bus.rd_out), 32'd13);

    // async reset mid-CALC
    issue(3'd3, 32'hDEADBEEF, 32'h12345678, 5'd21);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid.busy", 32'(bus.busy), 32'd0);
    chk("rst_mid.done", 32'(bus.done), 32'd0);
    chk("rst_mid.wr_en", 32'(bus.wr_en), 32'd0);
    chk("rst_mid.rd_out", 32'(bus.rd_out), 32'd0);
    chk("rst_mid.result", bus.result, 32'd0);
    @(negedge clk); rst = 1'b0;

    run_op("mul3x3_rd0", 3'd0, 32'd3, 32'd3, 5'd0, 32'd9);

    for (int n = 0; n < 24; n++) begin
      r_op = 3'($urandom_range(0, 7));
      r_a  = $urandom;
      r_b  = $urandom;
      r_rd = 5'($urandom_range(0, 31));
      case ($urandom_range(0, 7))
        0: r_b = 32'd0;
        1: begin r_a = 32'h80000000; r_b = 32'hFFFFFFFF; end
        2: r_b = 32'($urandom_range(1, 15));
        3: r_a = -32'($urandom_range(1, 1000));
        default: ;
      endcase
      run_op($sformatf("rand%0d_op%0d", n, r_op), r_op, r_a, r_b, r_rd, ref_model(r_op, r_a, r_b));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
